// File: rtl/board_store.sv
// board_store
//   Double-buffered Game-of-Life cell memory.
//   - The engine reads the current bank with one-cycle latency.
//   - The engine writes into the next bank.
//   - The banks swap once a full generation has been written.
//   - The display has its own read port on the current bank.
//   - The user edit port writes into the current bank.
//   - On reset, or on a start rising edge, a clear sweep zeroes both banks.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   start             new-game level; a rising edge restarts the clear sweep
//   evo_read_pos      engine read address -> evo_status (1-cycle latency)
//   evo_wden/_write_pos/_live   engine write into the next bank
//   disp_read_pos     display read address -> disp_status (1-cycle latency)
//   edit_wden/_pos/_val         user edit into the current bank
//   busy              clear sweep in progress
//   gen_done          one-cycle pulse on bank swap
//   bank_sel          index of the current bank
//   gen_count         generations completed since the last clear (wraps)
//
// State table
//   S_CLEAR | sweeping clr_addr 0..CELLS-1, zeroing both banks; reads return 0
//   S_RUN   | normal operation: reads, engine writes, edits, bank swaps
module board_store #(
  parameter int P_PARAM_M = 5,
  parameter int P_PARAM_N = 5,
  parameter int WIDTH     = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [2*WIDTH-1:0] evo_read_pos,
  output logic               evo_status,
  input  logic               evo_wden,
  input  logic [2*WIDTH-1:0] evo_write_pos,
  input  logic               evo_live,
  input  logic [2*WIDTH-1:0] disp_read_pos,
  output logic               disp_status,
  input  logic               edit_wden,
  input  logic [2*WIDTH-1:0] edit_pos,
  input  logic               edit_val,
  output logic               busy,
  output logic               gen_done,
  output logic               bank_sel,
  output logic [15:0]        gen_count
);

  localparam int CELLS = P_PARAM_M * P_PARAM_N;
  localparam int CW    = $clog2(CELLS + 1);
  localparam int AW    = (CELLS > 1) ? $clog2(CELLS) : 1;

  localparam logic [2*WIDTH-1:0] C_CELLS_POS = (2*WIDTH)'(CELLS);
  localparam logic [CW-1:0]      C_CELLS_CNT = CW'(CELLS);
  localparam logic [CW-1:0]      C_LAST      = CW'(CELLS - 1);

  typedef enum logic {S_CLEAR, S_RUN} state_t;

  state_t            r_state, w_state_nxt;
  logic              r_prev_start;
  logic [CELLS-1:0]  r_bank0, r_bank1;
  logic [CW-1:0]     r_clr_addr, r_wr_count;
  logic              r_bank_sel, r_gen_done;
  logic              r_evo_status, r_disp_status;
  logic [15:0]       r_gen_count;

  logic              w_start_edge, w_run, w_gen_full, w_swap, w_cur_sel;
  logic              w_evo_we, w_edit_we, w_evo_rd_ok, w_disp_rd_ok;
  logic [CELLS-1:0]  w_cur_bank;
  logic [AW-1:0]     w_clr_idx, w_evo_widx, w_edit_idx, w_evo_ridx, w_disp_ridx;

  assign w_start_edge = start & ~r_prev_start;
  assign w_run        = (r_state == S_RUN) & ~w_start_edge;
  assign w_gen_full   = (r_wr_count == C_CELLS_CNT);
  assign w_swap       = w_run & w_gen_full;

  // The swap cycle is the cycle after the last write of a generation.
  // In that cycle the swapped bank is already the current one for reads
  // and edits, even though bank_sel only flips on the following edge.
  assign w_cur_sel  = r_bank_sel ^ w_gen_full;
  assign w_cur_bank = w_cur_sel ? r_bank1 : r_bank0;

  assign w_evo_we     = w_run & evo_wden  & (evo_write_pos < C_CELLS_POS);
  assign w_edit_we    = w_run & edit_wden & (edit_pos      < C_CELLS_POS);
  assign w_evo_rd_ok  = evo_read_pos  < C_CELLS_POS;
  assign w_disp_rd_ok = disp_read_pos < C_CELLS_POS;

  assign w_clr_idx   = r_clr_addr[AW-1:0];
  assign w_evo_widx  = evo_write_pos[AW-1:0];
  assign w_edit_idx  = edit_pos[AW-1:0];
  assign w_evo_ridx  = evo_read_pos[AW-1:0];
  assign w_disp_ridx = disp_read_pos[AW-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_CLEAR;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_start_edge)
      w_state_nxt = S_CLEAR;
    else if ((r_state == S_CLEAR) && (r_clr_addr == C_LAST))
      w_state_nxt = S_RUN;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev_start  <= 1'b0;
      r_clr_addr    <= '0;
      r_wr_count    <= '0;
      r_bank_sel    <= 1'b0;
      r_gen_count   <= '0;
      r_gen_done    <= 1'b0;
      r_evo_status  <= 1'b0;
      r_disp_status <= 1'b0;
    end else begin
      r_prev_start  <= start;
      r_gen_done    <= w_swap;
      // Read-first: the registered read samples the bank before this
      // edge's edit lands.
      r_evo_status  <= w_run & w_evo_rd_ok  & w_cur_bank[w_evo_ridx];
      r_disp_status <= w_run & w_disp_rd_ok & w_cur_bank[w_disp_ridx];
      if (w_start_edge) begin
        r_clr_addr  <= '0;
        r_wr_count  <= '0;
        r_bank_sel  <= 1'b0;
        r_gen_count <= '0;
      end else if (r_state == S_CLEAR) begin
        r_clr_addr <= (r_clr_addr == C_LAST) ? '0 : r_clr_addr + CW'(1);
      end else if (w_swap) begin
        r_bank_sel  <= ~r_bank_sel;
        r_gen_count <= r_gen_count + 16'd1;
        // A write landing in the swap cycle already counts for the next
        // generation.
        r_wr_count  <= w_evo_we ? CW'(1) : '0;
      end else if (w_evo_we) begin
        r_wr_count <= r_wr_count + CW'(1);
      end
    end
  end

  // Cell storage is deliberately not reset; the clear sweep zeroes it.
  always_ff @(posedge clk) begin
    if ((r_state == S_CLEAR) && !w_start_edge) begin
      r_bank0[w_clr_idx] <= 1'b0;
      r_bank1[w_clr_idx] <= 1'b0;
    end
    if (w_evo_we) begin
      if (w_cur_sel) r_bank0[w_evo_widx] <= evo_live;
      else           r_bank1[w_evo_widx] <= evo_live;
    end
    if (w_edit_we) begin
      if (w_cur_sel) r_bank1[w_edit_idx] <= edit_val;
      else           r_bank0[w_edit_idx] <= edit_val;
    end
  end

  assign busy        = (r_state == S_CLEAR);
  assign gen_done    = r_gen_done;
  assign bank_sel    = r_bank_sel;
  assign gen_count   = r_gen_count;
  assign evo_status  = r_evo_status;
  assign disp_status = r_disp_status;

endmodule

// File: tb/tb_board_store.sv
// Testbench for board_store: a constant-expectation vector table, several
// hand-written multi-cycle sequences, and a randomized phase. Every cycle
// is also checked against a behavioural board model.
module tb_board_store;
  localparam int CELLS = 25;
  localparam int PW    = 24;

  logic          clk = 1'b0;
  logic          rst, start;
  logic [PW-1:0] evo_read_pos, evo_write_pos, disp_read_pos, edit_pos;
  logic          evo_wden, evo_live, edit_wden, edit_val;
  logic          evo_status, disp_status, busy, gen_done, bank_sel;
  logic [15:0]   gen_count;

  board_store #(.P_PARAM_M(5), .P_PARAM_N(5), .WIDTH(12)) dut (
    .clk(clk), .rst(rst), .start(start),
    .evo_read_pos(evo_read_pos), .evo_status(evo_status),
    .evo_wden(evo_wden), .evo_write_pos(evo_write_pos), .evo_live(evo_live),
    .disp_read_pos(disp_read_pos), .disp_status(disp_status),
    .edit_wden(edit_wden), .edit_pos(edit_pos), .edit_val(edit_val),
    .busy(busy), .gen_done(gen_done), .bank_sel(bank_sel), .gen_count(gen_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: two boards, a pending-swap flag derived from the
  // number of cells written this generation, and a clear countdown.
  bit mb[2][CELLS];
  bit m_sel, m_prev, e_evo, e_disp, e_gd;
  int m_wr, m_gen, m_clr;

  function automatic void model_reset();
    foreach (mb[b, c]) mb[b][c] = 1'b0;
    m_sel = 0; m_prev = 0; m_wr = 0; m_gen = 0; m_clr = CELLS;
    e_evo = 0; e_disp = 0; e_gd = 0;
  endfunction

  function automatic bit rd(input bit b, input logic [PW-1:0] p);
    if (p < CELLS) return mb[b][int'(p)];
    return 1'b0;
  endfunction

  function automatic void model_edge();
    bit se, swap, cur;
    if (rst) begin model_reset(); return; end
    se = start && !m_prev;
    m_prev = start;
    e_gd = 0;
    if (se) begin
      model_reset();
      m_prev = 1;
      return;
    end
    if (m_clr > 0) begin
      m_clr--; e_evo = 0; e_disp = 0;
      return;
    end
    swap = (m_wr == CELLS);
    cur  = m_sel ^ swap;
    e_evo  = rd(cur, evo_read_pos);
    e_disp = rd(cur, disp_read_pos);
    if (edit_wden && edit_pos < CELLS) mb[cur][int'(edit_pos)] = edit_val;
    if (swap) begin
      e_gd = 1; m_sel = !m_sel; m_gen = (m_gen + 1) % 65536; m_wr = 0;
    end
    if (evo_wden && evo_write_pos < CELLS) begin
      mb[!cur][int'(evo_write_pos)] = evo_live;
      m_wr++;
    end
  endfunction

  task automatic check_all();
    chk("busy",        busy,        (m_clr > 0));
    chk("bank_sel",    bank_sel,    m_sel);
    chk("gen_count",   gen_count,   m_gen);
    chk("gen_done",    gen_done,    e_gd);
    chk("evo_status",  evo_status,  e_evo);
    chk("disp_status", disp_status, e_disp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_edge();
    check_all();
  endtask

  task automatic idle();
    evo_wden = 0; evo_write_pos = '0; evo_live = 0;
    edit_wden = 0; edit_pos = '0; edit_val = 0;
    evo_read_pos = '0; disp_read_pos = '0;
  endtask

  task automatic clear_len(input string nm);
    int n = 0;
    do begin tick(); n++; end while (busy && n < 60);
    chk(nm, n, CELLS);
  endtask

  task automatic evo_write(input int p, input bit v);
    evo_wden = 1; evo_write_pos = PW'(p); evo_live = v;
    tick();
    evo_wden = 0;
  endtask

  typedef struct {
    logic [PW-1:0] evo_rd;
    logic [PW-1:0] disp_rd;
    bit            ed_we;
    logic [PW-1:0] ed_pos;
    bit            ed_val;
    bit            x_evo;
    bit            x_disp;
  } vec_t;

  vec_t tbl[$];
  int   gd_seen;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; start = 0; idle();
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 0; model_reset();

    // Power-up clear, then an all-zero board.
    chk("reset_busy", busy, 1);
    chk("reset_gen_done", gen_done, 0);
    clear_len("clear_len_reset");
    chk("post_clear_sel", bank_sel, 0);
    for (int p = 0; p < CELLS; p++) begin
      evo_read_pos = PW'(p); disp_read_pos = PW'(CELLS - 1 - p);
      tick();
      chk("clear_read_evo", evo_status, 0);
      chk("clear_read_disp", disp_status, 0);
    end
    idle();

    // Edits, read-first semantics, and out-of-range addresses.
    tbl.push_back('{24'd7,  24'd7,    1'b1, 24'd7,  1'b1, 1'b0, 1'b0});
    tbl.push_back('{24'd7,  24'd7,    1'b0, 24'd0,  1'b0, 1'b1, 1'b1});
    tbl.push_back('{24'd7,  24'd7,    1'b1, 24'd7,  1'b0, 1'b1, 1'b1});
    tbl.push_back('{24'd7,  24'd7,    1'b0, 24'd0,  1'b0, 1'b0, 1'b0});
    tbl.push_back('{24'd24, 24'd24,   1'b1, 24'd24, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{24'd24, 24'd25,   1'b0, 24'd0,  1'b0, 1'b1, 1'b0});
    tbl.push_back('{24'd30, 24'd4095, 1'b1, 24'd25, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{24'd0,  24'd24,   1'b1, 24'd0,  1'b1, 1'b0, 1'b1});
    tbl.push_back('{24'd0,  24'd0,    1'b1, 24'd24, 1'b0, 1'b1, 1'b1});
    tbl.push_back('{24'd24, 24'd0,    1'b1, 24'd7,  1'b1, 1'b0, 1'b1});
    tbl.push_back('{24'd7,  24'd24,   1'b0, 24'd0,  1'b0, 1'b1, 1'b0});
    tbl.push_back('{24'd7,  24'd7,    1'b1, 24'd7,  1'b0, 1'b1, 1'b1});
    tbl.push_back('{24'd7,  24'd0,    1'b1, 24'd0,  1'b0, 1'b0, 1'b1});
    tbl.push_back('{24'd0,  24'd0,    1'b0, 24'd0,  1'b0, 1'b0, 1'b0});
    foreach (tbl[i]) begin
      evo_read_pos = tbl[i].evo_rd; disp_read_pos = tbl[i].disp_rd;
      edit_wden = tbl[i].ed_we; edit_pos = tbl[i].ed_pos; edit_val = tbl[i].ed_val;
      tick();
      chk($sformatf("tbl%0d_evo", i), evo_status, tbl[i].x_evo);
      chk($sformatf("tbl%0d_disp", i), disp_status, tbl[i].x_disp);
    end
    idle();

    // A full generation with live = pos[0]; swap boundary.
    evo_read_pos = 24'd7; disp_read_pos = 24'd7;
    for (int i = 0; i < CELLS; i++) evo_write(i, i[0]);
    chk("swap_same_cycle_old", evo_status, 0);
    chk("swap_no_gd_yet", gen_done, 0);
    evo_read_pos = 24'd3;
    tick();
    chk("gen1_done", gen_done, 1);
    chk("gen1_sel", bank_sel, 1);
    chk("gen1_count", gen_count, 1);
    chk("gen1_read3", evo_status, 1);
    evo_read_pos = 24'd4;
    tick();
    chk("gen1_pulse_end", gen_done, 0);
    chk("gen1_read4", evo_status, 0);
    chk("gen1_disp7", disp_status, 1);

    // Out-of-range engine writes are neither stored nor counted.
    evo_read_pos = 24'd30;
    evo_write(25, 1);
    chk("oor_read30", evo_status, 0);
    evo_write(4095, 1);
    gd_seen = 0;
    for (int i = 0; i < CELLS - 1; i++) begin
      evo_write(i, 1'($urandom_range(1)));
      gd_seen += int'(gen_done);
    end
    tick();
    gd_seen += int'(gen_done);
    chk("oor_not_counted", gd_seen, 0);
    evo_write(CELLS - 1, 1);
    tick();
    chk("gen2_done", gen_done, 1);
    chk("gen2_count", gen_count, 2);
    idle();

    // New game in the middle of a generation.
    for (int i = 0; i < 10; i++) evo_write(i, 1);
    start = 1;
    tick();
    chk("start_busy", busy, 1);
    chk("start_sel", bank_sel, 0);
    chk("start_count", gen_count, 0);
    start = 0;
    clear_len("clear_len_start");
    for (int p = 0; p < CELLS; p++) begin
      evo_read_pos = PW'(p); disp_read_pos = PW'(p);
      tick();
      chk("start_read_zero", evo_status | disp_status, 0);
    end
    gd_seen = 0;
    for (int i = 0; i < CELLS - 1; i++) begin
      evo_write(i, 1); gd_seen += int'(gen_done);
    end
    tick(); gd_seen += int'(gen_done);
    chk("start_fresh_writes", gd_seen, 0);
    evo_write(CELLS - 1, 0);
    tick();
    chk("start_gen_done", gen_done, 1);

    // Asynchronous reset in the middle of a generation.
    for (int i = 0; i < 12; i++) evo_write(i, 1);
    @(posedge clk); #1;
    model_edge(); check_all();
    rst = 1;
    #1;
    model_reset();
    chk("arst_busy", busy, 1);
    chk("arst_count", gen_count, 0);
    chk("arst_sel", bank_sel, 0);
    chk("arst_evo", evo_status, 0);
    tick(); tick();
    @(negedge clk); rst = 0; model_reset();
    clear_len("clear_len_arst");
    gd_seen = 0;
    for (int i = 0; i < CELLS; i++) begin
      evo_write(i, 1); gd_seen += int'(gen_done);
    end
    chk("arst_25_needed", gd_seen, 0);
    tick();
    chk("arst_gen_done", gen_done, 1);

    // Randomized traffic, including start edges.
    for (int c = 0; c < 3000; c++) begin
      evo_wden      = ($urandom_range(3) != 0);
      evo_write_pos = ($urandom_range(9) == 0) ? PW'($urandom_range(25, 4095))
                                               : PW'($urandom_range(CELLS - 1));
      evo_live      = 1'($urandom_range(1));
      evo_read_pos  = PW'($urandom_range(31));
      disp_read_pos = ($urandom_range(15) == 0) ? 24'hFFFFFF : PW'($urandom_range(31));
      edit_wden     = ($urandom_range(3) == 0);
      edit_pos      = PW'($urandom_range(31));
      edit_val      = 1'($urandom_range(1));
      start         = ($urandom_range(199) == 0);
      tick();
    end
    start = 0; idle();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
